// File: rtl/knn_nn_search.sv
// Bus initiator that drives the KNN distance peripheral through a 1-nearest-neighbour
// search: programs the test point, streams data points in, keeps the closest one.
module knn_nn_search #(
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 8,
  parameter int A_RESET  = 0,
  parameter int A_ENABLE = 1,
  parameter int A_X1     = 2,
  parameter int A_Y1     = 3,
  parameter int A_X2     = 4,
  parameter int A_Y2     = 5,
  parameter int A_VALUE  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     test_x,
  input  logic [DATA_W-1:0]     test_y,
  input  logic                  pt_valid,
  output logic                  pt_ready,
  input  logic [DATA_W-1:0]     pt_x,
  input  logic [DATA_W-1:0]     pt_y,
  input  logic                  pt_last,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      best_idx,
  output logic [DATA_W-1:0]     best_dist,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ready,
  output logic [2:0]            dbg_state
);

  localparam int SW = DATA_W / 8;
  localparam int RW = SW + ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_WAIT_PT = 3'd2,
    S_POINT   = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t              state;
  logic [2:0]          step;
  logic                gap;
  logic                last_q;
  logic                have_best;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   tx, ty, px, py;

  assign dbg_state = state;

  // Request word {wstrb, address, wdata} for sub-step s of the setup or point sequence.
  function automatic logic [RW-1:0] req(input logic is_pt, input logic [2:0] s,
                                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [SW-1:0]     st;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] d;
    st = '1;
    ad = '0;
    d  = '0;
    if (!is_pt) begin
      case (s)
        3'd0:    begin ad = ADDR_W'(A_RESET); d = DATA_W'(1); end
        3'd1:    ad = ADDR_W'(A_RESET);
        3'd2:    begin ad = ADDR_W'(A_X1); d = a; end
        default: begin ad = ADDR_W'(A_Y1); d = b; end
      endcase
    end else begin
      case (s)
        3'd0:    begin ad = ADDR_W'(A_X2); d = a; end
        3'd1:    begin ad = ADDR_W'(A_Y2); d = b; end
        3'd2:    begin ad = ADDR_W'(A_ENABLE); d = DATA_W'(1); end
        3'd3:    begin ad = ADDR_W'(A_VALUE); st = '0; end
        default: ad = ADDR_W'(A_ENABLE);
      endcase
    end
    return {st, ad, d};
  endfunction

  // Handshake: a request is held stable while m_valid=1 until a cycle with m_ready=1;
  // m_valid then drops for exactly one gap cycle. m_ready is ignored while m_valid=0.
  // Point port: transfer occurs on a cycle with pt_valid && pt_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= '0;
      gap       <= 1'b0;
      last_q    <= 1'b0;
      have_best <= 1'b0;
      idx       <= '0;
      tx        <= '0;
      ty        <= '0;
      px        <= '0;
      py        <= '0;
      pt_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      best_idx  <= '0;
      best_dist <= '0;
      m_valid   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tx        <= test_x;
            ty        <= test_y;
            best_idx  <= '0;
            best_dist <= '0;
            idx       <= '0;
            have_best <= 1'b0;
            busy      <= 1'b1;
            step      <= '0;
            gap       <= 1'b0;
            m_valid   <= 1'b1;
            {m_wstrb, m_address, m_wdata} <= req(1'b0, 3'd0, test_x, test_y);
            state     <= S_SETUP;
          end
        end
        S_SETUP, S_POINT: begin
          if (m_valid) begin
            if (m_ready) begin
              m_valid <= 1'b0;
              gap     <= 1'b1;
              // Strict compare keeps the earlier index on equal distances.
              if (state == S_POINT && step == 3'd3) begin
                if (!have_best || m_rdata < best_dist) begin
                  best_dist <= m_rdata;
                  best_idx  <= idx;
                end
                have_best <= 1'b1;
              end
            end
          end else if (gap) begin
            gap <= 1'b0;
            if (state == S_SETUP && step == 3'd3) begin
              state    <= S_WAIT_PT;
              pt_ready <= 1'b1;
            end else if (state == S_POINT && step == 3'd4) begin
              idx <= idx + IDX_W'(1);
              if (last_q) begin
                state <= S_FINISH;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state    <= S_WAIT_PT;
                pt_ready <= 1'b1;
              end
            end else begin
              step    <= step + 3'd1;
              m_valid <= 1'b1;
              {m_wstrb, m_address, m_wdata} <= req(state == S_POINT, step + 3'd1,
                                                   (state == S_POINT) ? px : tx,
                                                   (state == S_POINT) ? py : ty);
            end
          end
        end
        S_WAIT_PT: begin
          if (pt_valid) begin
            px       <= pt_x;
            py       <= pt_y;
            last_q   <= pt_last;
            pt_ready <= 1'b0;
            step     <= '0;
            gap      <= 1'b0;
            m_valid  <= 1'b1;
            {m_wstrb, m_address, m_wdata} <= req(1'b1, 3'd0, pt_x, pt_y);
            state    <= S_POINT;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_nn_search.sv
// Bench for knn_nn_search: peripheral responder, bus/result scoreboard and a
// reference nearest-neighbour model over randomized and directed searches.
module tb_knn_nn_search;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int SW = DW / 8;
  localparam int TW = SW + AW + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] test_x = '0, test_y = '0;
  logic          pt_valid = 1'b0, pt_last = 1'b0;
  logic [DW-1:0] pt_x = '0, pt_y = '0;
  logic          pt_ready, busy, done;
  logic [IW-1:0] best_idx;
  logic [DW-1:0] best_dist;
  logic          m_valid;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  knn_nn_search dut (
    .clk(clk), .rst(rst), .start(start), .test_x(test_x), .test_y(test_y),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last),
    .busy(busy), .done(done), .best_idx(best_idx), .best_dist(best_dist),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [TW-1:0]    exp_q[$];
  logic [IW+DW-1:0] res_q[$];

  function automatic logic [DW-1:0] sqdist(input logic [DW-1:0] ax, ay, bx, by);
    logic [DW-1:0] dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return dx * dx + dy * dy;
  endfunction

  // Peripheral responder: ready registered from valid, optional extra wait cycles.
  int            resp_delay = 0;
  int            dist_mode = 0;
  int            wait_cnt = 0;
  logic [DW-1:0] r_x1 = '0, r_y1 = '0, r_x2 = '0, r_y2 = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready  <= 1'b0;
      wait_cnt <= 0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
    end else if (m_valid) begin
      if (wait_cnt >= resp_delay) begin
        m_ready  <= 1'b1;
        wait_cnt <= 0;
        if (m_wstrb == '0)
          m_rdata <= (m_address == 3'd6) ? ((dist_mode == 1) ? r_x2 : sqdist(r_x1, r_y1, r_x2, r_y2))
                                         : 32'hdead_beef;
        else
          case (m_address)
            3'd2: r_x1 <= m_wdata;
            3'd3: r_y1 <= m_wdata;
            3'd4: r_x2 <= m_wdata;
            3'd5: r_y2 <= m_wdata;
            default: ;
          endcase
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Monitor: bus protocol, transaction order and results, sampled on the falling edge.
  logic [TW-1:0]    obs_w;
  logic             pv = 1'b0, pr = 1'b0, pdone = 1'b0;
  logic [TW-1:0]    pword = '0;
  logic [TW-1:0]    e_txn;
  logic [IW+DW-1:0] e_res;
  assign obs_w = {m_wstrb, m_address, (m_wstrb == '0) ? '0 : m_wdata};

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0; pr = 1'b0; pdone = 1'b0;
    end else begin
      if (pv && !pr) begin
        checks = checks + 1;
        if (!(m_valid && obs_w == pword)) begin
          errors = errors + 1;
          $display("FAIL bus_hold actual=%0d/%h required=1/%h", m_valid, obs_w, pword);
        end
      end
      if (pv && pr) begin
        checks = checks + 1;
        if (m_valid) begin
          errors = errors + 1;
          $display("FAIL bus_gap actual m_valid=1 required 0");
        end
      end
      if (m_valid && m_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL bus_unexpected actual=%h required none", obs_w);
        end else begin
          e_txn = exp_q.pop_front();
          if (obs_w !== e_txn) begin
            errors = errors + 1;
            $display("FAIL bus_txn actual=%h required=%h", obs_w, e_txn);
          end
        end
      end
      if (done) begin
        checks = checks + 1;
        if (res_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL result_unexpected actual idx=%0d dist=%0d", best_idx, best_dist);
        end else begin
          e_res = res_q.pop_front();
          if ({best_idx, best_dist} !== e_res) begin
            errors = errors + 1;
            $display("FAIL result actual idx=%0d dist=%0d required idx=%0d dist=%0d",
                     best_idx, best_dist, e_res[DW+IW-1:DW], e_res[DW-1:0]);
          end
        end
        checks = checks + 1;
        if (pdone) begin
          errors = errors + 1;
          $display("FAIL done_width actual 2+ cycles required 1");
        end
      end
      pv = m_valid; pr = m_ready; pword = obs_w; pdone = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks = checks + 1;
    if (act !== req_v) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic do_start(input logic [DW-1:0] tx, input logic [DW-1:0] ty);
    exp_q.push_back({4'hF, 3'd0, 32'd1});
    exp_q.push_back({4'hF, 3'd0, 32'd0});
    exp_q.push_back({4'hF, 3'd2, tx});
    exp_q.push_back({4'hF, 3'd3, ty});
    start = 1'b1; test_x = tx; test_y = ty;
    tick();
    start = 1'b0;
  endtask

  task automatic feed_point(input logic [DW-1:0] x, input logic [DW-1:0] y,
                            input logic last, output int waited);
    exp_q.push_back({4'hF, 3'd4, x});
    exp_q.push_back({4'hF, 3'd5, y});
    exp_q.push_back({4'hF, 3'd1, 32'd1});
    exp_q.push_back({4'h0, 3'd6, 32'd0});
    exp_q.push_back({4'hF, 3'd1, 32'd0});
    pt_valid = 1'b1; pt_x = x; pt_y = y; pt_last = last;
    waited = 0;
    while (waited < 3000) begin
      @(negedge clk);
      waited++;
      if (pt_ready) break;
    end
    if (!pt_ready) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL pt_ready_timeout actual=0 required=1");
    end
    tick();
    pt_valid = 1'b0; pt_last = 1'b0;
  endtask

  task automatic wait_done(input bit poke);
    int n = 0;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      checks = checks + 1; errors = errors + 1;
      $display("FAIL done_timeout actual=0 required=1");
    end else if (poke) begin
      start = 1'b1; test_x = 32'd77; test_y = 32'd88;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("restart_after_done", {m_valid, busy}, 2'b00);
      end
    end
  endtask

  logic [DW-1:0] pxs[8], pys[8];

  function automatic logic [DW-1:0] ref_dist(input int mode, input logic [DW-1:0] tx, ty, x, y);
    return (mode == 1) ? x : sqdist(tx, ty, x, y);
  endfunction

  task automatic run_search(input logic [DW-1:0] tx, input logic [DW-1:0] ty, input int n,
                            input int mode, input int delay, input bit lat,
                            input bit poke_busy, input bit poke_done);
    logic [DW-1:0] bd, d;
    logic [IW-1:0] bi;
    int            w;
    bd = ref_dist(mode, tx, ty, pxs[0], pys[0]);
    bi = '0;
    for (int i = 1; i < n; i++) begin
      d = ref_dist(mode, tx, ty, pxs[i], pys[i]);
      if (d < bd) begin bd = d; bi = IW'(i); end
    end
    res_q.push_back({bi, bd});
    dist_mode = mode;
    resp_delay = delay;
    do_start(tx, ty);
    if (poke_busy) begin
      start = 1'b1; test_x = 32'h55; test_y = 32'h66;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      feed_point(pxs[i], pys[i], i == n - 1, w);
      if (lat && i < 2) check(i == 0 ? "latency_setup" : "latency_point", 64'(w), i == 0 ? 64'd13 : 64'd16);
    end
    wait_done(poke_done);
    tick(); tick(); tick();
    @(negedge clk);
    check("hold_best_idx", 64'(best_idx), 64'(bi));
    check("hold_best_dist", 64'(best_dist), 64'(bd));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 0);
    check("rst_m_address", 64'(m_address), 0);
    check("rst_m_wdata", 64'(m_wdata), 0);
    check("rst_m_wstrb", 64'(m_wstrb), 0);
    check("rst_pt_ready", 64'(pt_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_best_idx", 64'(best_idx), 0);
    check("rst_best_dist", 64'(best_dist), 0);
    tick();
    pt_valid = 1'b1; pt_x = 32'd9; pt_y = 32'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_no_accept", {pt_ready, m_valid, busy}, 3'b000);
    end
    tick();
    pt_valid = 1'b0;

    // Directed search from origin: distances 25, 2, 50.
    pxs[0] = 3; pys[0] = 4; pxs[1] = 1; pys[1] = 1; pxs[2] = 5; pys[2] = 5;
    run_search(0, 0, 3, 0, 0, 1'b1, 1'b0, 1'b0);
    check("directed_idx", 64'(best_idx), 1);
    check("directed_dist", 64'(best_dist), 2);

    // Tie: 7, 7, 9 keeps the first.
    pxs[0] = 7; pxs[1] = 7; pxs[2] = 9; pys[0] = 1; pys[1] = 2; pys[2] = 3;
    run_search(0, 0, 3, 1, 0, 1'b0, 1'b0, 1'b0);
    check("tie_idx", 64'(best_idx), 0);
    check("tie_dist", 64'(best_dist), 7);

    // Slow responder plus ignored start pulses during busy and on done.
    pxs[0] = 3; pys[0] = 4; pxs[1] = 1; pys[1] = 1; pxs[2] = 5; pys[2] = 5;
    run_search(0, 0, 3, 0, 5, 1'b0, 1'b1, 1'b1);
    check("slow_idx", 64'(best_idx), 1);
    check("slow_dist", 64'(best_dist), 2);

    // Single point.
    pxs[0] = 20; pys[0] = 30;
    run_search(10, 10, 1, 0, 1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the distance read.
    resp_delay = 3; dist_mode = 0;
    do_start(10, 10);
    feed_point(13, 14, 1'b1, w);
    n = 0;
    while (n < 200 && !(m_valid && m_address == 3'd6 && m_wstrb == '0)) begin
      @(negedge clk);
      n++;
    end
    check("reached_read", 64'(m_valid && m_address == 3'd6), 1);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_state", {m_valid, busy, pt_ready, done}, 4'b0000);
    tick();

    for (int s = 0; s < 20; s++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          pxs[i] = $urandom_range(0, 3); pys[i] = $urandom_range(0, 3);
        end else begin
          pxs[i] = $urandom_range(0, 1000); pys[i] = $urandom_range(0, 1000);
        end
      end
      run_search($urandom_range(0, 1000), $urandom_range(0, 1000), n, 0,
                 $urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
    end

    repeat (5) tick();
    check("txn_queue_empty", 64'(exp_q.size()), 0);
    check("res_queue_empty", 64'(res_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
